decode_stage: RTL

- Registered RV32I/RV64I decode stage between fetch and execute, with a valid/ready handshake on both sides.
- Parametrised in XLEN, which enables the RV64 word ops and the 64-bit load/store ops.
- Optional two-entry skid buffer, so `in_ready` is registered.
- Flags illegal encodings instead of silently defaulting them.
- Supports pipeline flush.

---
 rtl/alu_pkg.sv | 15 +
 rtl/decode_pkg.sv | 86 ++++++++
 rtl/decode_logic.sv | 198 +++++++++++++++++++
 rtl/decode_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings used by the decode stage and the execute ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/decode_pkg.sv
// Decode-stage types: opcodes, operand/immediate selectors, LSU ops and the micro-op record.
package decode_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // LSU op encoding, widened to 4 bits for the RV64 accesses
    localparam logic [3:0] LSU_NONE = 4'd0;
    localparam logic [3:0] LSU_LB   = 4'd1;
    localparam logic [3:0] LSU_LH   = 4'd2;
    localparam logic [3:0] LSU_LW   = 4'd3;
    localparam logic [3:0] LSU_LBU  = 4'd4;
    localparam logic [3:0] LSU_LHU  = 4'd5;
    localparam logic [3:0] LSU_SB   = 4'd6;
    localparam logic [3:0] LSU_SH   = 4'd7;
    localparam logic [3:0] LSU_SW   = 4'd8;
    localparam logic [3:0] LSU_LD   = 4'd9;
    localparam logic [3:0] LSU_LWU  = 4'd10;
    localparam logic [3:0] LSU_SD   = 4'd11;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // pc and imm are carried at the widest XLEN; the stage trims them on output
    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [3:0]  alu_op;
        logic [3:0]  lsu_op;
        logic [2:0]  branch_op;
        a_sel_e      a_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        is_jalr;
        logic        is_word;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
    } uop_t;

    // Sign-extended immediate for a given format, always 64 bits wide
    function automatic logic [63:0] imm_extract(input imm_fmt_e fmt, input logic [31:0] inst);
        case (fmt)
            IMM_I:   imm_extract = {{52{inst[31]}}, inst[31:20]};
            IMM_S:   imm_extract = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm_extract = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm_extract = {{32{inst[31]}}, inst[31:12], 12'h000};
            IMM_J:   imm_extract = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm_extract = 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I/RV64I decoder: instruction word and pc in, micro-op out.
module decode_logic
    import decode_pkg::*;
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output uop_t            uop_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       funct7_ok_s;
    logic       illegal_s;
    imm_fmt_e   fmt_s;

    assign opcode_s = inst_i[6:0];
    assign funct3_s = inst_i[14:12];
    assign funct7_s = inst_i[31:25];
    // R-type: only 0100000 with ADD/SUB or SRL/SRA is a legal non-zero funct7
    assign funct7_ok_s = (funct7_s == 7'b0000000) ||
                         ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));

    // ALU op from funct3; alt selects SUB/SRA where the caller allows it
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            3'b111:  alu_sel = ALU_AND;
            default: alu_sel = ALU_ADD;
        endcase
    endfunction

    // Opcode decode, illegal detection and enable suppression for illegal encodings
    always_comb begin
        uop_o           = '0;
        illegal_s       = 1'b0;
        fmt_s           = IMM_NONE;
        uop_o.pc        = 64'(pc_i);
        uop_o.rd        = inst_i[11:7];
        uop_o.rs1       = inst_i[19:15];
        uop_o.rs2       = inst_i[24:20];
        uop_o.alu_op    = ALU_ADD;
        uop_o.lsu_op    = LSU_NONE;
        uop_o.branch_op = funct3_s;
        uop_o.a_sel     = A_SEL_RS1;

        if (inst_i[1:0] != 2'b11) begin
            illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_LUI: begin
                    fmt_s           = IMM_U;
                    uop_o.a_sel     = A_SEL_ZERO;
                    uop_o.alu_src   = 1'b1;
                    uop_o.reg_write = 1'b1;
                end
                OPC_AUIPC: begin
                    fmt_s           = IMM_U;
                    uop_o.a_sel     = A_SEL_PC;
                    uop_o.alu_src   = 1'b1;
                    uop_o.reg_write = 1'b1;
                end
                OPC_JAL: begin
                    fmt_s           = IMM_J;
                    uop_o.a_sel     = A_SEL_PC;
                    uop_o.alu_src   = 1'b1;
                    uop_o.jump      = 1'b1;
                    uop_o.reg_write = 1'b1;
                end
                OPC_JALR: begin
                    fmt_s           = IMM_I;
                    uop_o.alu_src   = 1'b1;
                    uop_o.jump      = 1'b1;
                    uop_o.reg_write = 1'b1;
                    uop_o.is_jalr   = 1'b1;
                    illegal_s       = (funct3_s != 3'b000);
                end
                OPC_BRANCH: begin
                    fmt_s         = IMM_B;
                    uop_o.a_sel   = A_SEL_PC;
                    uop_o.alu_src = 1'b1;
                    uop_o.branch  = 1'b1;
                    illegal_s     = (funct3_s == 3'b010) || (funct3_s == 3'b011);
                end
                OPC_LOAD: begin
                    fmt_s           = IMM_I;
                    uop_o.alu_src   = 1'b1;
                    uop_o.mem_read  = 1'b1;
                    uop_o.reg_write = 1'b1;
                    case (funct3_s)
                        3'b000:  uop_o.lsu_op = LSU_LB;
                        3'b001:  uop_o.lsu_op = LSU_LH;
                        3'b010:  uop_o.lsu_op = LSU_LW;
                        3'b100:  uop_o.lsu_op = LSU_LBU;
                        3'b101:  uop_o.lsu_op = LSU_LHU;
                        3'b011: begin
                            uop_o.lsu_op = LSU_LD;
                            illegal_s    = !RV64;
                        end
                        3'b110: begin
                            uop_o.lsu_op = LSU_LWU;
                            illegal_s    = !RV64;
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end
                OPC_STORE: begin
                    fmt_s           = IMM_S;
                    uop_o.alu_src   = 1'b1;
                    uop_o.mem_write = 1'b1;
                    case (funct3_s)
                        3'b000:  uop_o.lsu_op = LSU_SB;
                        3'b001:  uop_o.lsu_op = LSU_SH;
                        3'b010:  uop_o.lsu_op = LSU_SW;
                        3'b011: begin
                            uop_o.lsu_op = LSU_SD;
                            illegal_s    = !RV64;
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end
                OPC_OP_IMM: begin
                    fmt_s           = IMM_I;
                    uop_o.alu_src   = 1'b1;
                    uop_o.reg_write = 1'b1;
                    // inst[30] only distinguishes SRAI; for ADDI it is an immediate bit
                    uop_o.alu_op    = alu_sel(funct3_s, (funct3_s == 3'b101) && inst_i[30]);
                    case (funct3_s)
                        3'b001:  illegal_s = (inst_i[31:26] != 6'b000000) || (inst_i[25] && !RV64);
                        3'b101:  illegal_s = ({inst_i[31], inst_i[29:26]} != 5'b00000) || (inst_i[25] && !RV64);
                        default: illegal_s = 1'b0;
                    endcase
                end
                OPC_OP: begin
                    uop_o.reg_write = 1'b1;
                    uop_o.alu_op    = alu_sel(funct3_s, inst_i[30]);
                    illegal_s       = !funct7_ok_s;
                end
                OPC_OP_IMM_32: begin
                    fmt_s           = IMM_I;
                    uop_o.alu_src   = 1'b1;
                    uop_o.reg_write = 1'b1;
                    uop_o.is_word   = 1'b1;
                    uop_o.alu_op    = alu_sel(funct3_s, (funct3_s == 3'b101) && inst_i[30]);
                    case (funct3_s)
                        3'b000:  illegal_s = !RV64;
                        3'b001:  illegal_s = !RV64 || (funct7_s != 7'b0000000);
                        3'b101:  illegal_s = !RV64 || !funct7_ok_s;
                        default: illegal_s = 1'b1;
                    endcase
                end
                OPC_OP_32: begin
                    uop_o.reg_write = 1'b1;
                    uop_o.is_word   = 1'b1;
                    uop_o.alu_op    = alu_sel(funct3_s, inst_i[30]);
                    case (funct3_s)
                        3'b000, 3'b001, 3'b101: illegal_s = !RV64 || !funct7_ok_s;
                        default:                illegal_s = 1'b1;
                    endcase
                end
                OPC_MISC_MEM: begin
                    // FENCE and FENCE.I retire as no-ops in this in-order pipeline
                    illegal_s = (funct3_s != 3'b000) && (funct3_s != 3'b001);
                end
                OPC_SYSTEM: begin
                    if (inst_i == INST_ECALL) begin
                        uop_o.ecall = 1'b1;
                    end else if (inst_i == INST_EBREAK) begin
                        uop_o.ebreak = 1'b1;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                default: illegal_s = 1'b1;
            endcase
        end

        uop_o.imm       = imm_extract(fmt_s, inst_i);
        uop_o.illegal   = illegal_s;
        uop_o.reg_write = uop_o.reg_write & ~illegal_s;
        uop_o.mem_read  = uop_o.mem_read  & ~illegal_s;
        uop_o.mem_write = uop_o.mem_write & ~illegal_s;
        uop_o.branch    = uop_o.branch    & ~illegal_s;
        uop_o.jump      = uop_o.jump      & ~illegal_s;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute with valid/ready on both sides,
// an optional two-entry skid buffer and a priority flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic [3:0]      out_lsu_op,
    output logic [2:0]      out_branch_op,
    output logic [1:0]      out_a_sel,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_alu_src,
    output logic            out_is_jalr,
    output logic            out_is_word,
    output logic            out_ecall,
    output logic            out_ebreak,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    uop_t   dec_s;
    uop_t   head_q, head_d;
    uop_t   skid_q, skid_d;
    state_e state_q, state_d;
    logic   valid_q, valid_d;
    logic   rdy_q, rdy_d;
    logic   in_ready_s;
    logic   accept_s;
    logic   consume_s;

    decode_logic #(
        .XLEN (XLEN)
    ) u_decode_logic (
        .inst_i (in_inst),
        .pc_i   (in_pc),
        .uop_o  (dec_s)
    );

    // Ready toward fetch: registered occupancy flag with skid, else pass-through of downstream ready
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (SKID != 0) begin
            in_ready_s = rdy_q;
        end else begin
            in_ready_s = !valid_q || out_ready;
        end
    end

    // Next-state for the holding registers; flush overrides every other event
    always_comb begin
        head_d    = head_q;
        skid_d    = skid_q;
        state_d   = state_q;
        valid_d   = valid_q;
        accept_s  = in_valid && in_ready_s && !flush;
        consume_s = valid_q && out_ready;

        if (flush) begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
        end else if (SKID != 0) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_d  = dec_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        head_d  = dec_s;
                        state_d = ST_ONE;
                    end else if (accept_s) begin
                        skid_d  = dec_s;
                        state_d = ST_TWO;
                    end else if (consume_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain of the older entry can happen
                    if (consume_s) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            valid_d = (state_d != ST_EMPTY);
        end else begin
            if (accept_s) begin
                head_d  = dec_s;
                valid_d = 1'b1;
            end else if (consume_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            state_d = valid_d ? ST_ONE : ST_EMPTY;
        end

        rdy_d = (state_d != ST_TWO);
    end

    // Stage registers; the ready flag resets high and is masked by rst on the output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (XLEN < 64) begin : g_narrow
            logic unused_hi_s;
            assign unused_hi_s = ^{head_q.pc[63:XLEN], head_q.imm[63:XLEN]};
        end
    endgenerate

    assign in_ready      = in_ready_s;
    assign out_valid     = valid_q;
    assign out_pc        = head_q.pc[XLEN-1:0];
    assign out_rd        = head_q.rd;
    assign out_rs1       = head_q.rs1;
    assign out_rs2       = head_q.rs2;
    assign out_imm       = head_q.imm[XLEN-1:0];
    assign out_alu_op    = head_q.alu_op;
    assign out_lsu_op    = head_q.lsu_op;
    assign out_branch_op = head_q.branch_op;
    assign out_a_sel     = head_q.a_sel;
    assign out_reg_write = head_q.reg_write;
    assign out_mem_read  = head_q.mem_read;
    assign out_mem_write = head_q.mem_write;
    assign out_branch    = head_q.branch;
    assign out_jump      = head_q.jump;
    assign out_alu_src   = head_q.alu_src;
    assign out_is_jalr   = head_q.is_jalr;
    assign out_is_word   = head_q.is_word;
    assign out_ecall     = head_q.ecall;
    assign out_ebreak    = head_q.ebreak;
    assign out_illegal   = head_q.illegal;

endmodule
